// File: rtl/full_sub_beh.sv
// Purpose: registered WIDTH-bit ripple-borrow full subtractor, {bo,d} = a - b - bi.
// Latency: 1 clock from in_valid to out_valid; one operand set accepted per clock.
// Backpressure: none; the block is always ready and results are never stalled.
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset (clears d, bo, out_valid, ovf)
//   in_valid   a/b/bi are valid this cycle
//   a, b       unsigned minuend / subtrahend, WIDTH bits
//   bi         borrow-in (weight 1)
//   d, bo      registered difference and borrow-out
//   out_valid  d/bo were loaded on the previous edge
//   ovf        two's-complement overflow flag, present only when the
//              FULL_SUB_OVF_EN macro is defined
module full_sub_beh #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
`ifdef FULL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // Borrow chain: br[0] is the external borrow-in, br[WIDTH] the borrow-out.
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = bi;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            // A borrow leaves bit i when the subtrahend side (b plus incoming
            // borrow) exceeds a[i].
            br[i+1]  = (~a[i] & (b[i] | br[i])) | (b[i] & br[i]);
        end
    end

`ifdef FULL_SUB_OVF_EN
    // Signed overflow only possible when operand signs differ; it occurred
    // if the result sign then disagrees with the minuend sign.
    logic ovf_nxt;
    assign ovf_nxt = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`endif

    // Reset wins over in_valid; operands presented during reset are dropped.
    // Without in_valid the result registers hold and only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d         <= '0;
            bo        <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d   <= diff;
                bo  <= br[WIDTH];
`ifdef FULL_SUB_OVF_EN
                ovf <= ovf_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_sub_beh.sv
// Bench for full_sub_beh: one WIDTH=1 and one WIDTH=8 instance on a shared
// clock and reset, checked against an integer-arithmetic reference model.
module tb_full_sub_beh;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v1, a1, b1, bi1, d1, bo1, ov1;
    logic       v8, bi8, bo8, ov8;
    logic [7:0] a8, b8, d8;
`ifdef FULL_SUB_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    int checks = 0;
    int errors = 0;

    // Model state (what the outputs should show after the next edge).
    logic       m_d1, m_bo1, m_ov1;
    logic [7:0] m_d8;
    logic       m_bo8, m_ov8, m_ovf8;

    // Truth table indexed by {a,b,bi}, entries {d,bo}.
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    full_sub_beh #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .bi(bi1),
        .d(d1), .bo(bo1),
`ifdef FULL_SUB_OVF_EN
        .ovf(ovf1),
`endif
        .out_valid(ov1)
    );

    full_sub_beh #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .bi(bi8),
        .d(d8), .bo(bo8),
`ifdef FULL_SUB_OVF_EN
        .ovf(ovf8),
`endif
        .out_valid(ov8)
    );

    // Plain integer subtraction; negative result means a borrow out, the
    // difference is the result taken modulo 2^width.
    function automatic void ref_sub(input int a, input int b, input int bi, input int width,
                                    output int d, output bit bo);
        int r;
        r  = a - b - bi;
        bo = (r < 0);
        d  = (r + (1 << width)) % (1 << width);
    endfunction

    // Overflow rule on 8-bit values: signs differ and result sign != minuend sign.
    function automatic bit ref_ovf8(input int a, input int b, input int d);
        return (((a >> 7) & 1) != ((b >> 7) & 1)) && (((d >> 7) & 1) != ((a >> 7) & 1));
    endfunction

    // Update the model for an accepted transaction or a reset edge.
    task automatic model_edge(input bit rst, input bit va, input bit vb);
        int  d;
        bit  bo;
        if (rst) begin
            m_d1 = 1'b0; m_bo1 = 1'b0; m_ov1 = 1'b0;
            m_d8 = 8'h00; m_bo8 = 1'b0; m_ov8 = 1'b0; m_ovf8 = 1'b0;
        end else begin
            m_ov1 = va;
            m_ov8 = vb;
            if (va) begin
                ref_sub(int'(a1), int'(b1), int'(bi1), 1, d, bo);
                m_d1 = d[0]; m_bo1 = bo;
            end
            if (vb) begin
                ref_sub(int'(a8), int'(b8), int'(bi8), 8, d, bo);
                m_d8 = d[7:0]; m_bo8 = bo;
                m_ovf8 = ref_ovf8(int'(a8), int'(b8), d);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic tick();
        model_edge(!rst_n, v1, v8);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; bi8 = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if ({d1, bo1, ov1} !== 3'b000) begin
                errors++;
                $display("FAIL reset_w1: got d=%b bo=%b out_valid=%b, expected 0 0 0", d1, bo1, ov1);
            end
            checks++;
            if ({d8, bo8, ov8} !== 10'h000) begin
                errors++;
                $display("FAIL reset_w8: got d=%h bo=%b out_valid=%b, expected 00 0 0", d8, bo8, ov8);
            end
`ifdef FULL_SUB_OVF_EN
            checks++;
            if (ovf8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf: got %b, expected 0", ovf8);
            end
`endif
        end
        rst_n = 1'b1;
        v1 = 1'b0; v8 = 1'b0;
    endtask

    task automatic test_truth_table();
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, bi1} = 3'(i);
            tick();
            checks++;
            if ({d1, bo1, ov1} !== {tt[i], 1'b1}) begin
                errors++;
                $display("FAIL truth_%0d: got d=%b bo=%b out_valid=%b, expected d=%b bo=%b out_valid=1",
                         i, d1, bo1, ov1, tt[i][1], tt[i][0]);
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_hold();
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; bi1 = 1'b1;
        tick();
        checks++;
        if ({d1, bo1, ov1} !== 3'b111) begin
            errors++;
            $display("FAIL hold_load: got d=%b bo=%b out_valid=%b, expected 1 1 1", d1, bo1, ov1);
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if ({d1, bo1, ov1} !== 3'b110) begin
                errors++;
                $display("FAIL hold_keep: got d=%b bo=%b out_valid=%b, expected 1 1 0", d1, bo1, ov1);
            end
        end
    endtask

    task automatic test_wrap();
        v8 = 1'b1; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b1;
        tick();
        checks++;
        if ({d8, bo8, ov8} !== {8'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_zero: got d=%h bo=%b out_valid=%b, expected FF 1 1", d8, bo8, ov8);
        end
        a8 = 8'h80; b8 = 8'h01; bi8 = 1'b0;
        tick();
        checks++;
        if ({d8, bo8, ov8} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_80: got d=%h bo=%b out_valid=%b, expected 7F 0 1", d8, bo8, ov8);
        end
`ifdef FULL_SUB_OVF_EN
        checks++;
        if (ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_80_01: got %b, expected 1", ovf8);
        end
`endif
        v8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        v8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bi8 = 1'b0;
        tick();
        checks++;
        if ({d8, bo8, ov8} !== {8'h02, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: got d=%h bo=%b out_valid=%b, expected 02 0 1", d8, bo8, ov8);
        end
`ifdef FULL_SUB_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_05_03: got %b, expected 0", ovf8);
        end
`endif
        a8 = 8'h03; b8 = 8'h05;
        tick();
        checks++;
        if ({d8, bo8, ov8} !== {8'hFE, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second: got d=%h bo=%b out_valid=%b, expected FE 1 1", d8, bo8, ov8);
        end
        v8 = 1'b0;
        tick();
        checks++;
        if ({d8, bo8, ov8} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_idle: got d=%h bo=%b out_valid=%b, expected FE 1 0", d8, bo8, ov8);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 29) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            v8  = ($urandom_range(0, 3) != 0);
            a1  = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
            a8  = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
            if (n % 50 == 0) begin
                a8 = 8'h00; b8 = 8'hFF; bi8 = 1'b1;
            end
            tick();
            checks++;
            if ({d1, bo1, ov1} !== {m_d1, m_bo1, m_ov1}) begin
                errors++;
                $display("FAIL rand_w1_%0d: got d=%b bo=%b out_valid=%b, expected d=%b bo=%b out_valid=%b",
                         n, d1, bo1, ov1, m_d1, m_bo1, m_ov1);
            end
            checks++;
            if ({d8, bo8, ov8} !== {m_d8, m_bo8, m_ov8}) begin
                errors++;
                $display("FAIL rand_w8_%0d: got d=%h bo=%b out_valid=%b, expected d=%h bo=%b out_valid=%b",
                         n, d8, bo8, ov8, m_d8, m_bo8, m_ov8);
            end
`ifdef FULL_SUB_OVF_EN
            checks++;
            if (ovf8 !== m_ovf8) begin
                errors++;
                $display("FAIL rand_ovf_%0d: got %b, expected %b", n, ovf8, m_ovf8);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;
        test_reset();
        test_truth_table();
        test_hold();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
